// File: rtl/ps8_req_tracker.sv
// ============================================================================
// ps8_req_tracker : pending-request counters feeding the ps8 priority selector.
// Optional starvation guard: TRACKER_STARVE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ps8_req_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 2,
  parameter int IDX_W = 3
`ifdef TRACKER_STARVE_EN
  ,
  parameter int STARVE_LIM = 15
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     push,
  input  logic             stall,
  input  logic             clr_ovf,
  input  logic [N-1:0]     gnt,
  output logic [N-1:0]     req,
  output logic             sel_en,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     overflow,
  output logic             gnt_err,
  output logic             busy
`ifdef TRACKER_STARVE_EN
  ,
  output logic             starve
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     pending;
  logic [N-1:0]     taken;
  logic [N-1:0]     ovf_evt;
  logic [IDX_W-1:0] hi_idx;
  logic             gnt_multi;
  logic             take_any;
  logic             err_evt;

  generate
    for (genvar g = 0; g < N; g++) begin : g_pend
      assign pending[g] = (cnt[g] != '0);
      assign ovf_evt[g] = push[g] & ~taken[g] & (cnt[g] == CNT_MAX);
    end
  endgenerate

  assign busy   = |pending;
  assign sel_en = ~stall & |req;

  // Only the highest asserted grant bit is honoured; anything else is an error.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) hi_idx = IDX_W'(i);
    end
    gnt_multi = ((gnt & (gnt - N'(1))) != '0);
    take_any  = sel_en & (|gnt) & pending[hi_idx];
    taken     = take_any ? (N'(1) << hi_idx) : '0;
    err_evt   = sel_en & (|gnt) & (gnt_multi | ~pending[hi_idx]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({push[i], taken[i]})
          2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // A fresh error event in the clearing cycle keeps the sticky bit set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= '0;
      gnt_err     <= 1'b0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      overflow    <= (overflow & ~{N{clr_ovf}}) | ovf_evt;
      gnt_err     <= (gnt_err & ~clr_ovf) | err_evt;
      grant_valid <= take_any;
      if (take_any) grant_idx <= hi_idx;
    end
  end

`ifdef TRACKER_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

  logic [WAIT_W-1:0] wait_cnt [N];
  logic [N-1:0]      starving;
  logic [N-1:0]      req_mask;
  logic              found;

  generate
    for (genvar g = 0; g < N; g++) begin : g_starve
      assign starving[g] = (wait_cnt[g] == WAIT_MAX);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (taken[i] || !pending[i])  wait_cnt[i] <= '0;
        else if (!starving[i])        wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
      end
    end
  end

  // Hide requesters above the highest starving one so ps8 must pick it.
  always_comb begin
    found    = 1'b0;
    req_mask = '1;
    for (int i = N - 1; i >= 0; i--) begin
      req_mask[i] = ~(|starving) | found | starving[i];
      found       = found | starving[i];
    end
  end

  assign req    = pending & req_mask;
  assign starve = |starving;
`else
  assign req = pending;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps8_req_tracker.sv
// ============================================================================
// tb_ps8_req_tracker : directed bench with a behavioural ps8 (highest index wins).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps8_req_tracker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] push;
  logic       stall;
  logic       clr_ovf;
  logic [7:0] gnt;
  logic [7:0] req;
  logic       sel_en;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] overflow;
  logic       gnt_err;
  logic       busy;
`ifdef TRACKER_STARVE_EN
  logic       starve;
`endif

  logic       force_en;
  logic [7:0] force_gnt;
  int         passed = 0;
  int         total  = 0;
  int         pulses;

  always #5 clock = ~clock;

  ps8_req_tracker dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (push),
    .stall       (stall),
    .clr_ovf     (clr_ovf),
    .gnt         (gnt),
    .req         (req),
    .sel_en      (sel_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .overflow    (overflow),
    .gnt_err     (gnt_err),
    .busy        (busy)
`ifdef TRACKER_STARVE_EN
    ,
    .starve      (starve)
`endif
  );

  function automatic logic [7:0] hi_bit(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 8'(1) << i;
    return r;
  endfunction

  always_comb begin
    if (force_en)    gnt = force_gnt;
    else if (sel_en) gnt = hi_bit(req);
    else             gnt = '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; push = '0; stall = 1'b0; clr_ovf = 1'b0;
    force_en = 1'b0; force_gnt = '0;
    repeat (2) step();
    #1;
    check("rst_req", req, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_gv", grant_valid, 1'b0);
    check("rst_idx", grant_idx, 3'd0);
    check("rst_ovf", overflow, 8'h00);
    check("rst_err", gnt_err, 1'b0);
    check("rst_selen", sel_en, 1'b0);
    reset_n = 1'b1;
    step();

    // async reset in the middle of traffic
    push = 8'hFF;
    step();
    push = 8'h00;
    #1 check("t1_req_full", req, 8'hFF);
    step();
    #1;
    check("t1_gv", grant_valid, 1'b1);
    check("t1_idx", grant_idx, 3'd7);
    check("t1_req_7f", req, 8'h7F);
    reset_n = 1'b0;
    #1;
    check("t1_req_async", req, 8'h00);
    check("t1_busy_async", busy, 1'b0);
    check("t1_gv_async", grant_valid, 1'b0);
    check("t1_idx_async", grant_idx, 3'd0);
    step();
    reset_n = 1'b1;
    step();
    #1;
    check("t1_busy_after", busy, 1'b0);
    check("t1_req_after", req, 8'h00);

    // two requesters, highest index first
    push = 8'h18;
    step();
    push = 8'h00;
    #1 check("t2_req", req, 8'h18);
    step();
    #1;
    check("t2_gv1", grant_valid, 1'b1);
    check("t2_idx1", grant_idx, 3'd4);
    check("t2_req1", req, 8'h08);
    step();
    #1;
    check("t2_gv2", grant_valid, 1'b1);
    check("t2_idx2", grant_idx, 3'd3);
    check("t2_req2", req, 8'h00);
    check("t2_busy", busy, 1'b0);
    step();
    #1;
    check("t2_gv_end", grant_valid, 1'b0);
    check("t2_idx_hold", grant_idx, 3'd3);

    // saturation under stall, clear, then drain
    stall = 1'b1;
    push  = 8'h04;
    repeat (4) step();
    push = 8'h00;
    #1;
    check("t3_ovf", overflow, 8'h04);
    check("t3_req", req, 8'h04);
    check("t3_selen", sel_en, 1'b0);
    check("t3_gv", grant_valid, 1'b0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    #1 check("t3_ovf_clr", overflow, 8'h00);
    stall = 1'b0;
    pulses = 0;
    repeat (6) begin
      step();
      if (grant_valid && grant_idx == 3'd2) pulses++;
    end
    check("t3_pulses", pulses, 3);
    check("t3_busy", busy, 1'b0);

    // push and grant in the same cycle at max count
    stall = 1'b1;
    push  = 8'h20;
    repeat (3) step();
    stall = 1'b0;
    step();
    push  = 8'h00;
    stall = 1'b1;
    #1;
    check("t4_gv", grant_valid, 1'b1);
    check("t4_idx", grant_idx, 3'd5);
    check("t4_ovf", overflow, 8'h00);
    stall = 1'b0;
    pulses = 0;
    repeat (6) begin
      step();
      if (grant_valid && grant_idx == 3'd5) pulses++;
    end
    check("t4_pulses", pulses, 3);

    // malformed grants
    stall = 1'b1;
    push  = 8'h30;
    step();
    push      = 8'h00;
    force_en  = 1'b1;
    force_gnt = 8'h30;
    stall     = 1'b0;
    #1 check("t5_selen", sel_en, 1'b1);
    step();
    #1;
    check("t5_gv", grant_valid, 1'b1);
    check("t5_idx", grant_idx, 3'd5);
    check("t5_err_multi", gnt_err, 1'b1);
    check("t5_req", req, 8'h10);
    force_gnt = 8'h00;
    clr_ovf   = 1'b1;
    step();
    clr_ovf = 1'b0;
    #1;
    check("t5_err_clr", gnt_err, 1'b0);
    check("t5_gv_none", grant_valid, 1'b0);
    force_gnt = 8'h01;
    step();
    #1;
    check("t5_err_zero", gnt_err, 1'b1);
    check("t5_gv_ign", grant_valid, 1'b0);
    check("t5_req_kept", req, 8'h10);
    clr_ovf = 1'b1;
    step();
    #1 check("t5_err_wins", gnt_err, 1'b1);
    force_gnt = 8'h00;
    step();
    clr_ovf = 1'b0;
    #1 check("t5_err_clr2", gnt_err, 1'b0);
    force_en = 1'b0;
    step();
    #1;
    check("t5_gv_drain", grant_valid, 1'b1);
    check("t5_idx_drain", grant_idx, 3'd4);
    check("t5_busy", busy, 1'b0);

`ifdef TRACKER_STARVE_EN
    // low requester starved by a constantly refreshed high requester
    push = 8'h81;
    step();
    push = 8'h80;
    repeat (14) step();
    #1;
    check("t6_req_pre", req, 8'h81);
    check("t6_starve_pre", starve, 1'b0);
    step();
    #1;
    check("t6_req_mask", req, 8'h01);
    check("t6_starve", starve, 1'b1);
    step();
    #1;
    check("t6_gv", grant_valid, 1'b1);
    check("t6_idx", grant_idx, 3'd0);
    check("t6_starve_off", starve, 1'b0);
    push = 8'h00;
    for (int k = 0; k < 20 && busy; k++) step();
    check("t6_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
